// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand-fetch stage: register-file geometry,
// the captured operand bundle, and the operand-select helper.
package operand_fetch_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    data_t;

    typedef struct packed {
        data_t    a;
        data_t    b;
        reg_idx_t rd;
        logic     rd_we;
    } bundle_t;

    // Register 0 is hard-wired to zero; otherwise the in-flight write-back wins over the stale read.
    function automatic data_t select_operand(input reg_idx_t idx,
                                             input logic     bypass_hit,
                                             input data_t    wb_data,
                                             input data_t    rf_data);
        if (idx == REG_ZERO) return '0;
        if (bypass_hit)      return wb_data;
        return rf_data;
    endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writer issues and cleared when its write-back is observed.
module of_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 set_en,
    input  logic [REG_IDX_W-1:0] set_idx,
    input  logic                 clr_en,
    input  logic [REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0] lookup_rs,
    input  logic [REG_IDX_W-1:0] lookup_rt,
    input  logic [REG_IDX_W-1:0] lookup_rd,
    output logic                 pend_rs,
    output logic                 pend_rt,
    output logic                 pend_rd
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        pending_d = pending_q;
        if (clr_en && clr_idx != REG_ZERO) pending_d[clr_idx] = 1'b0;
        // Applied after the clear so a new writer outranks a retiring one on the same index.
        if (set_en && set_idx != REG_ZERO) pending_d[set_idx] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    assign pend_rs = pending_q[lookup_rs];
    assign pend_rt = pending_q[lookup_rt];
    assign pend_rd = pending_q[lookup_rd];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: stalls on scoreboard hazards, optionally forwards the
// write-back value, and registers the operand bundle for the execute stage.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rs,
    input  logic [REG_IDX_W-1:0] in_rt,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic                 in_rd_we,
    output logic [REG_IDX_W-1:0] rf_rs,
    output logic [REG_IDX_W-1:0] rf_rt,
    input  logic [DATA_W-1:0]    rf_saidaA,
    input  logic [DATA_W-1:0]    rf_saidaB,
    input  logic                 wb_wr,
    input  logic [REG_IDX_W-1:0] wb_controle,
    input  logic [DATA_W-1:0]    wb_entrada,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_a,
    output logic [DATA_W-1:0]    out_b,
    output logic [REG_IDX_W-1:0] out_rd,
    output logic                 out_rd_we
);

    logic    pend_rs, pend_rt, pend_rd;
    logic    rs_nz, rt_nz, rd_nz;
    logic    byp_rs, byp_rt;
    logic    hazard, accept, sb_set;
    logic    out_valid_q, out_valid_d;
    bundle_t bundle_q, bundle_d;

    assign rf_rs = in_rs;
    assign rf_rt = in_rt;

    of_scoreboard u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .set_en    (sb_set),
        .set_idx   (in_rd),
        .clr_en    (wb_wr),
        .clr_idx   (wb_controle),
        .lookup_rs (in_rs),
        .lookup_rt (in_rt),
        .lookup_rd (in_rd),
        .pend_rs   (pend_rs),
        .pend_rt   (pend_rt),
        .pend_rd   (pend_rd)
    );

    always_comb begin
        rs_nz  = (in_rs != REG_ZERO);
        rt_nz  = (in_rt != REG_ZERO);
        rd_nz  = (in_rd != REG_ZERO);
        // A write-back to index 0 never matches a non-zero source, so it is never forwarded.
        byp_rs = BYPASS && wb_wr && (wb_controle == in_rs) && rs_nz;
        byp_rt = BYPASS && wb_wr && (wb_controle == in_rt) && rt_nz;

        // WAW is never waived: the older write must retire before a new owner claims the register.
        hazard = in_valid && ((pend_rs && rs_nz && !byp_rs) ||
                              (pend_rt && rt_nz && !byp_rt) ||
                              (pend_rd && in_rd_we && rd_nz));

        in_ready = !reset && !hazard && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        sb_set   = accept && in_rd_we && rd_nz;

        bundle_d    = bundle_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            bundle_d.a     = select_operand(in_rs, byp_rs, wb_entrada, rf_saidaA);
            bundle_d.b     = select_operand(in_rt, byp_rt, wb_entrada, rf_saidaB);
            bundle_d.rd    = in_rd;
            bundle_d.rd_we = in_rd_we;
            out_valid_d    = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: these are plain control/data flops, so they are reset; a large storage array would not be.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = bundle_q.a;
    assign out_b     = bundle_q.b;
    assign out_rd    = bundle_q.rd;
    assign out_rd_we = bundle_q.rd_we;

endmodule
